// File: rtl/ifetch_pkg.sv
// -----------------------------------------------------------------------------
// ifetch_pkg
//
// Shared types and constants for the instruction fetch block.
//
// Contents:
//   fetch_entry_t  - one buffered fetch: byte PC plus the instruction word.
//   WORD_SHIFT     - shift that turns a byte PC into a word index.
//   INST_NOP       - canonical RISC-V NOP (addi x0, x0, 0). Decode uses it
//                    when it has to squash a slot.
//   alignPc()      - clears the two low bits of a byte PC.
// -----------------------------------------------------------------------------
package ifetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam int          WORD_SHIFT = 2;
    localparam logic [31:0] INST_NOP   = 32'h0000_0013;

    // Instructions are always word aligned, so the low two bits of any
    // requested PC are dropped rather than treated as an error.
    function automatic logic [31:0] alignPc(input logic [31:0] pc);
        return pc & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// -----------------------------------------------------------------------------
// ifetch_fifo
//
// Small synchronous FIFO of fetch_entry_t that buffers fetched instructions
// between the memory read and decode.
//
// Parameters:
//   DEPTH  - number of entries; power of two, at least 2.
//
// Ports:
//   clk    in   clock, all state changes on the rising edge
//   reset  in   synchronous active-high reset; also clears the storage
//   flush  in   drop every buffered entry (storage contents kept)
//   push   in   write din at the tail
//   pop    in   retire the head entry
//   din    in   entry to write
//   dout   out  head entry
//   count  out  number of valid entries, 0..DEPTH
// -----------------------------------------------------------------------------
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  fetch_entry_t               din,
    output fetch_entry_t               dout,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t          entries_q [DEPTH];
    logic [PW-1:0]         rdPtr_q;
    logic [PW-1:0]         wrPtr_q;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_d;
    logic                  doPush;
    logic                  doPop;

    // Qualify the requests against the occupancy. A push into a full buffer
    // is only accepted when the head leaves in the same cycle, which is what
    // keeps full-rate streaming going without a bubble.
    always_comb begin
        doPop   = pop && (count_q != '0);
        doPush  = push && ((count_q != CW'(DEPTH)) || doPop);
        count_d = count_q + CW'(doPush) - CW'(doPop);
    end

    // Pointers wrap naturally because DEPTH is a power of two. Reset wipes
    // the storage so the head reads as zero afterwards; a flush only rewinds
    // the pointers since stale words behind count = 0 are never presented.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else if (flush) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                entries_q[wrPtr_q] <= din;
                wrPtr_q            <= wrPtr_q + PW'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    assign dout  = entries_q[rdPtr_q];
    assign count = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Fetch front end of the RISC-V core. Owns the program counter, reads one
// word per cycle from a combinational instruction memory, buffers the result
// in ifetch_fifo and presents it to decode over a valid/ready handshake.
// Branch resolution can redirect the PC at any time, which also empties the
// buffer.
//
// Build option:
//   IFETCH_BYPASS_EN - when defined, a fetch into an empty buffer is shown
//                      to decode in the same cycle; if decode takes it, the
//                      entry never enters the buffer.
//
// Parameters:
//   RESET_PC  - byte address fetched first after reset (word aligned)
//   DEPTH     - fetch buffer entries (power of two, >= 2)
//
// Ports:
//   clk             in   clock
//   reset           in   synchronous active-high reset
//   mem_addr        out  word index into instruction memory (pc >> 2)
//   mem_re          out  read enable, high in every cycle a fetch happens
//   mem_rdata       in   word at mem_addr, same cycle
//   redirect_valid  in   load redirect_pc and drop buffered instructions
//   redirect_pc     in   new byte PC, low two bits ignored
//   inst_valid      out  head instruction available
//   inst_ready      in   decode accepts the head instruction
//   inst_data       out  head instruction word
//   inst_pc         out  byte PC of the head instruction
// -----------------------------------------------------------------------------
module instruction_fetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    input  logic [31:0] mem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   pc_q;
    logic [31:0]   pc_d;
    logic [CW-1:0] fifoCount;
    fetch_entry_t  fifoHead;
    fetch_entry_t  fifoDin;
    logic          fifoValid;
    logic          fifoPop;
    logic          fetch;
    logic          push;
    logic          bypassHit;

    // A fetch is allowed whenever there is room, or when the buffer is full
    // but its head is leaving this cycle. The pop term is built from the
    // buffer's own valid rather than inst_valid so that the bypass path
    // cannot close a combinational loop through inst_ready.
    always_comb begin
        fifoValid = (fifoCount != '0);
        fifoPop   = fifoValid && inst_ready;
        fetch     = !reset && !redirect_valid
                    && ((fifoCount < CW'(DEPTH)) || fifoPop);
    end

`ifdef IFETCH_BYPASS_EN
    // Empty buffer plus a fetch: forward the memory word straight to decode.
    assign bypassHit = fetch && !fifoValid;
`else
    assign bypassHit = 1'b0;
`endif

    // A bypassed word that decode accepts on the spot is already consumed
    // and must not be buffered a second time.
    always_comb begin
        push    = fetch && !(bypassHit && inst_ready);
        fifoDin = '{pc: pc_q, inst: mem_rdata};
    end

    // Redirect wins over a fetch in the same cycle; the PC only advances on
    // an actual fetch and silently wraps at the top of the address space.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = alignPc(redirect_pc);
        end else if (fetch) begin
            pc_d = pc_q + 32'd4;
        end
    end

    // Program counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    ifetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redirect_valid),
        .push  (push),
        .pop   (fifoPop),
        .din   (fifoDin),
        .dout  (fifoHead),
        .count (fifoCount)
    );

    // The address is driven every cycle, even without a read, so the
    // memory sees a stable index.
    assign mem_addr   = pc_q >> WORD_SHIFT;
    assign mem_re     = fetch;
    assign inst_valid = fifoValid || bypassHit;
    assign inst_data  = bypassHit ? mem_rdata : fifoHead.inst;
    assign inst_pc    = bypassHit ? pc_q      : fifoHead.pc;

endmodule
